// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID stage and
// the write-back register file.
interface wb_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic [31:0]      ID_inst;
    logic [31:0]      WB_inst;
    logic [XLEN-1:0]  WB_i_data;
    logic             WB_reg_wen;
    logic [XLEN-1:0]  ID_rs1_data;
    logic [XLEN-1:0]  ID_rs2_data;
    logic [4:0]       dbg_addr;
    logic [XLEN-1:0]  dbg_data;
    logic [CNT_W-1:0] instret;

    modport master (
        output ID_inst,
        output WB_inst,
        output WB_i_data,
        output WB_reg_wen,
        output dbg_addr,
        input  ID_rs1_data,
        input  ID_rs2_data,
        input  dbg_data,
        input  instret
    );

    modport slave (
        input  ID_inst,
        input  WB_inst,
        input  WB_i_data,
        input  WB_reg_wen,
        input  dbg_addr,
        output ID_rs1_data,
        output ID_rs2_data,
        output dbg_data,
        output instret
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back register file: 32 x XLEN integer registers with
// write-first operand bypass, registered debug read and instret counter.
module wb_regfile #(
    parameter int          XLEN     = 32,
    parameter int          CNT_W    = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    logic [XLEN-1:0]  regs_q [32];
    logic [XLEN-1:0]  dbg_data_q;
    logic [XLEN-1:0]  dbg_data_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             wr_en;
    logic             retire;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;

    assign rd  = bus.WB_inst[11:7];
    assign rs1 = bus.ID_inst[19:15];
    assign rs2 = bus.ID_inst[24:20];

    assign wr_en  = bus.WB_reg_wen && (rd != 5'd0);
    assign retire = (bus.WB_inst != NOP_INST) &&
                    (bus.WB_inst != 32'd0);

    // Bypass stays live while rst is high; it only looks at inputs.
    always_comb begin
        rs1_data = '0;
        if (rs1 == 5'd0) begin
            rs1_data = '0;
        end else if (wr_en && (rs1 == rd)) begin
            rs1_data = bus.WB_i_data;
        end else begin
            rs1_data = regs_q[rs1];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2 == 5'd0) begin
            rs2_data = '0;
        end else if (wr_en && (rs2 == rd)) begin
            rs2_data = bus.WB_i_data;
        end else begin
            rs2_data = regs_q[rs2];
        end
    end

    always_comb begin
        dbg_data_d = '0;
        if (bus.dbg_addr != 5'd0) begin
            dbg_data_d = regs_q[bus.dbg_addr];
        end
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            dbg_data_q <= '0;
            instret_q  <= '0;
        end else begin
            if (wr_en) begin
                regs_q[rd] <= bus.WB_i_data;
            end
            dbg_data_q <= dbg_data_d;
            instret_q  <= instret_d;
        end
    end

    assign bus.ID_rs1_data = rs1_data;
    assign bus.ID_rs2_data = rs2_data;
    assign bus.dbg_data    = dbg_data_q;
    assign bus.instret     = instret_q;

    // Only the register-address fields of ID_inst matter here.
    logic unused_id;
    assign unused_id = ^{bus.ID_inst[31:25], bus.ID_inst[14:0]};

endmodule
